// File: rtl/divider_prog.sv
// rtl/divider_prog.sv - runtime-programmable clock divider with tick strobe and glitch-free reload
// Optional phase-align input enabled by DIVIDER_PROG_SYNC_EN.
module divider_prog #(
  parameter int WIDTH    = 24,
  parameter int DIV_RST  = 12000000,
  parameter int HIGH_RST = 6000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] div_in,
  input  logic [WIDTH-1:0] high_in,
`ifdef DIVIDER_PROG_SYNC_EN
  input  logic             sync,
`endif
  output logic             pending,
  output logic             tick,
  output logic             clkout
);

  localparam logic [WIDTH-1:0] ONE        = WIDTH'(1);
  localparam logic [WIDTH-1:0] DIV_RST_W  = (DIV_RST == 0) ? ONE : WIDTH'(DIV_RST);
  localparam logic [WIDTH-1:0] HIGH_RST_W = WIDTH'(HIGH_RST);

  logic [WIDTH-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] div_act, div_act_nxt;
  logic [WIDTH-1:0] high_act, high_act_nxt;
  logic [WIDTH-1:0] div_sh, div_sh_nxt;
  logic [WIDTH-1:0] high_sh, high_sh_nxt;
  logic             pending_q, pending_nxt;
  logic             tick_q, tick_nxt;
  logic             clkout_q, clkout_nxt;

  logic [WIDTH-1:0] div_in_m;
  logic [WIDTH-1:0] new_div;
  logic [WIDTH-1:0] new_high;
  logic             have_new;
  logic             wrap;
  logic             restart;

  // A load in the same cycle as an apply point bypasses the shadow registers.
  always_comb begin
    div_in_m = (div_in == '0) ? ONE : div_in;
    have_new = pending_q | load;
    new_div  = load ? div_in_m : div_sh;
    new_high = load ? high_in  : high_sh;
    wrap     = (cnt >= (div_act - ONE));
`ifdef DIVIDER_PROG_SYNC_EN
    restart  = wrap | sync;
`else
    restart  = wrap;
`endif
  end

  always_comb begin
    cnt_nxt      = cnt;
    div_act_nxt  = div_act;
    high_act_nxt = high_act;
    div_sh_nxt   = div_sh;
    high_sh_nxt  = high_sh;
    pending_nxt  = pending_q;
    tick_nxt     = 1'b0;
    clkout_nxt   = clkout_q;

    if (load) begin
      div_sh_nxt  = div_in_m;
      high_sh_nxt = high_in;
    end

    if (en) begin
      clkout_nxt = (cnt < high_act);
      if (restart) begin
        cnt_nxt  = '0;
        tick_nxt = 1'b1;
        if (have_new) begin
          div_act_nxt  = new_div;
          high_act_nxt = new_high;
          pending_nxt  = 1'b0;
        end
      end else begin
        cnt_nxt = cnt + ONE;
        if (load) begin
          pending_nxt = 1'b1;
        end
      end
    end else if (have_new) begin
      // Output is frozen while disabled, so new values can take effect at once.
      div_act_nxt  = new_div;
      high_act_nxt = new_high;
      cnt_nxt      = '0;
      pending_nxt  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      div_act   <= DIV_RST_W;
      high_act  <= HIGH_RST_W;
      div_sh    <= DIV_RST_W;
      high_sh   <= HIGH_RST_W;
      pending_q <= 1'b0;
      tick_q    <= 1'b0;
      clkout_q  <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      div_act   <= div_act_nxt;
      high_act  <= high_act_nxt;
      div_sh    <= div_sh_nxt;
      high_sh   <= high_sh_nxt;
      pending_q <= pending_nxt;
      tick_q    <= tick_nxt;
      clkout_q  <= clkout_nxt;
    end
  end

  assign pending = pending_q;
  assign tick    = tick_q;
  assign clkout  = clkout_q;

endmodule

// File: doc/divider_prog.md
Name: divider_prog

Overview:
Runtime-programmable integer clock divider and enable generator. It is the successor to the fixed-divisor divider: the divisor and high-time are loadable at run time, changes are glitch-free, and a one-cycle tick strobe is added. It sits beside the system clock and drives LED/PWM/timer logic with either a slow square wave or a clock-enable pulse.

Parameters:
WIDTH, 24, counter/divisor bit-width
DIV_RST, 12000000, divisor active after reset (must fit WIDTH)
HIGH_RST, 6000000, high-time (cycles clkout=1 per period) active after reset

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
en  input  1  count enable; 0 freezes the divider
load  input  1  1-cycle strobe: capture div_in/high_in into shadow registers
div_in  input  WIDTH  requested divisor; 0 treated as 1
high_in  input  WIDTH  requested high-time in cycles
pending  output  1  shadow values captured but not yet active
tick  output  1  1-cycle pulse, once per output period
clkout  output  1  divided output, registered

Behaviour:
- Reset (async, active-high): cnt=0, div_act=DIV_RST, high_act=HIGH_RST, shadow regs=reset values, pending=0, tick=0, clkout=0.
- Enabled cycle (en=1), wrap = (cnt >= div_act-1):
  - wrap: cnt<=0, tick<=1; apply new values if pending or load is asserted (see load rules).
  - otherwise: cnt<=cnt+1, tick<=0.
  - clkout <= (cnt < high_act), using pre-edge cnt and high_act. This gives one cycle of lag, consistent with the existing divider.
- Period = div_act cycles. High time = min(high_act, div_act) cycles.
  - high_act=0: clkout stays 0.
  - high_act>=div_act: clkout stays 1.
- div_act=1: cnt stays 0, tick=1 every enabled cycle, clkout = (high_act!=0).
- Load rules:
  - load=1 captures div_in (0 mapped to 1) and high_in into shadow regs and sets pending=1.
  - Load while pending: shadow is overwritten; the last load wins.
  - Load in the same enabled cycle as wrap: the new values become active at that wrap directly, and pending stays 0.
  - Active values otherwise change only at a wrap, never mid-period, so there are no runt pulses.
- Disabled cycle (en=0): cnt and clkout hold, tick<=0.
  - If pending (or load asserted), apply shadow immediately, set cnt<=0, clear pending.
- Wrap uses >=, so a cnt beyond div_act-1 cannot occur or run away.
- Counter arithmetic is modulo 2^WIDTH. No overflow is possible because cnt < div_act <= 2^WIDTH-1.
- Reset mid-period: immediate return to reset state; any pending load is discarded.

Optional Feature:
- Macro DIVIDER_PROG_SYNC_EN.
- Defined: adds input port sync (1 bit).
  - sync=1 on an enabled cycle forces cnt<=0 and tick<=1, and applies pending values, exactly as a wrap.
  - clkout follows the normal rule.
  - Used to phase-align several dividers.
  - sync has priority over a normal increment.
- Not defined: port absent, no sync logic synthesised, behaviour as above.

Test Plan:
- Reset release, DIV_RST=4, HIGH_RST=2, en=1 -> clkout 1,1,0,0 repeating after 1-cycle lag; tick high every 4th cycle; pending=0.
- Mid-period load div_in=6, high_in=3 at cnt=1 -> pending=1 until next wrap; current 4-cycle period completes unchanged; then 6-cycle periods with 3 high.
- Load coincident with wrap (div_in=3, high_in=1) -> pending never asserts; next period is 3 cycles, 1 high.
- div_in=0, high_in=5 -> treated as 1: tick every cycle, clkout constant 1. Then high_in=0 -> clkout constant 0 after apply.
- en=0 for 10 cycles at cnt=2, with a load of div_in=8 during it -> cnt frozen, tick=0, new value applied immediately with cnt=0. On en=1, 8-cycle periods start.
- Async rst pulse mid-period while pending=1 -> outputs return to reset values immediately without waiting for clk; pending cleared; old DIV_RST timing resumes.
- (DIVIDER_PROG_SYNC_EN) two instances DIV=5 started 2 cycles apart; common sync pulse -> ticks coincide thereafter.
